demux_dispatch_ctrl: RTL and testbench

DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

---
 rtl/demux_dispatch_ctrl.sv | 137 +++++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: single-word holding controller that dispatches each
// accepted word to one of four channels by round-robin over enabled channels.
// Optional per-channel drain counters are compiled in when DEMUX_DISPATCH_CNT_EN
// is defined (adds cnt_clr input and cnt_flat output).
module demux_dispatch_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        chan_en,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [1:0]        out_sel,
  output logic              busy
`ifdef DEMUX_DISPATCH_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [31:0]       cnt_flat
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic       drain;
  logic       accept;
  logic [1:0] search_base;
  logic [1:0] next_sel;

  // Handshake terms; in_ready deliberately ignores in_valid.
  always_comb begin
    drain    = (state_q == HOLD) && out_ready[sel_q];
    in_ready = (chan_en != 4'b0000) && ((state_q == IDLE) || drain);
    accept   = in_valid && in_ready;
  end

  // Round-robin search; during a drain the just-drained channel acts as the pointer.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    search_base = drain ? sel_q : ptr_q;
    next_sel    = search_base;
    found       = 1'b0;
    idx         = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = search_base + 2'(k);
      if (!found && chan_en[idx]) begin
        next_sel = idx;
        found    = 1'b1;
      end
    end
  end

  // Next-state and register updates for the holding FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (drain) begin
      ptr_d   = sel_q;
      state_d = IDLE;
    end
    if (accept) begin
      data_d  = in_data;
      sel_d   = next_sel;
      state_d = HOLD;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  // Output decode: one-hot valid only while holding.
  always_comb begin
    out_data  = data_q;
    out_sel   = sel_q;
    busy      = (state_q == HOLD);
    out_valid = (state_q == HOLD) ? (4'b0001 << sel_q) : 4'b0000;
  end

`ifdef DEMUX_DISPATCH_CNT_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  // Saturating per-channel drain counters; clear wins over increment.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        cnt_d[i] = '0;
      end else if (drain && (sel_q == 2'(i)) && (cnt_q[i] != 8'hFF)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Flatten counters, channel i at bits [8i+7:8i].
  always_comb begin
    cnt_flat = '0;
    for (int unsigned i = 0; i < 4; i++) cnt_flat[8*i +: 8] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed, table-driven bench for demux_dispatch_ctrl.
module tb_demux_dispatch_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] chan_en;
  logic [7:0] out_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [1:0] out_sel;
  logic       busy;
`ifdef DEMUX_DISPATCH_CNT_EN
  logic        cnt_clr;
  logic [31:0] cnt_flat;
`endif

  int errors = 0;
  int checks = 0;

  demux_dispatch_ctrl #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .chan_en   (chan_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .busy      (busy)
`ifdef DEMUX_DISPATCH_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .cnt_flat  (cnt_flat)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic [3:0] en;
    logic [3:0] rdy;
    logic       ir;
    logic [3:0] ov;
    logic [7:0] od;
    logic       bsy;
    logic [1:0] sel;
  } vec_t;

  vec_t vecs[28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // Fields: iv, d, en, rdy | in_ready, out_valid, out_data, busy, out_sel (sampled before the edge)
    // Round-robin over all channels, back-to-back
    vecs[0]  = '{1'b0, 8'h00, 4'hF, 4'hF, 1'b1, 4'b0000, 8'h00, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 8'h11, 4'hF, 4'hF, 1'b1, 4'b0000, 8'h00, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 8'h22, 4'hF, 4'hF, 1'b1, 4'b0001, 8'h11, 1'b1, 2'd0};
    vecs[3]  = '{1'b1, 8'h33, 4'hF, 4'hF, 1'b1, 4'b0010, 8'h22, 1'b1, 2'd1};
    vecs[4]  = '{1'b1, 8'h44, 4'hF, 4'hF, 1'b1, 4'b0100, 8'h33, 1'b1, 2'd2};
    vecs[5]  = '{1'b1, 8'h55, 4'hF, 4'hF, 1'b1, 4'b1000, 8'h44, 1'b1, 2'd3};
    vecs[6]  = '{1'b0, 8'h00, 4'hF, 4'hF, 1'b1, 4'b0001, 8'h55, 1'b1, 2'd0};
    vecs[7]  = '{1'b0, 8'h00, 4'hF, 4'hF, 1'b1, 4'b0000, 8'h55, 1'b0, 2'd0};
    // Sparse enable 1010: channels 1,3,1,3
    vecs[8]  = '{1'b1, 8'h61, 4'hA, 4'hF, 1'b1, 4'b0000, 8'h55, 1'b0, 2'd0};
    vecs[9]  = '{1'b1, 8'h62, 4'hA, 4'hF, 1'b1, 4'b0010, 8'h61, 1'b1, 2'd1};
    vecs[10] = '{1'b1, 8'h63, 4'hA, 4'hF, 1'b1, 4'b1000, 8'h62, 1'b1, 2'd3};
    vecs[11] = '{1'b1, 8'h64, 4'hA, 4'hF, 1'b1, 4'b0010, 8'h63, 1'b1, 2'd1};
    vecs[12] = '{1'b0, 8'h00, 4'hA, 4'hF, 1'b1, 4'b1000, 8'h64, 1'b1, 2'd3};
    vecs[13] = '{1'b0, 8'h00, 4'hA, 4'hF, 1'b1, 4'b0000, 8'h64, 1'b0, 2'd3};
    // Stall on channel 0, chan_en and other ready bits wiggled while held
    vecs[14] = '{1'b1, 8'hA5, 4'hF, 4'h0, 1'b1, 4'b0000, 8'h64, 1'b0, 2'd3};
    vecs[15] = '{1'b1, 8'hB6, 4'h2, 4'h0, 1'b0, 4'b0001, 8'hA5, 1'b1, 2'd0};
    vecs[16] = '{1'b1, 8'hB6, 4'hF, 4'hE, 1'b0, 4'b0001, 8'hA5, 1'b1, 2'd0};
    vecs[17] = '{1'b1, 8'hB6, 4'h2, 4'h0, 1'b0, 4'b0001, 8'hA5, 1'b1, 2'd0};
    vecs[18] = '{1'b0, 8'h00, 4'h2, 4'h1, 1'b1, 4'b0001, 8'hA5, 1'b1, 2'd0};
    // No channel enabled: nothing accepted
    vecs[19] = '{1'b0, 8'h00, 4'h0, 4'hF, 1'b0, 4'b0000, 8'hA5, 1'b0, 2'd0};
    vecs[20] = '{1'b1, 8'h77, 4'h0, 4'hF, 1'b0, 4'b0000, 8'hA5, 1'b0, 2'd0};
    vecs[21] = '{1'b1, 8'h77, 4'h0, 4'hF, 1'b0, 4'b0000, 8'hA5, 1'b0, 2'd0};
    vecs[22] = '{1'b1, 8'h77, 4'h0, 4'hF, 1'b0, 4'b0000, 8'hA5, 1'b0, 2'd0};
    // Single enabled channel 2, no bubbles
    vecs[23] = '{1'b1, 8'hC1, 4'h4, 4'hF, 1'b1, 4'b0000, 8'hA5, 1'b0, 2'd0};
    vecs[24] = '{1'b1, 8'hC2, 4'h4, 4'hF, 1'b1, 4'b0100, 8'hC1, 1'b1, 2'd2};
    vecs[25] = '{1'b1, 8'hC3, 4'h4, 4'hF, 1'b1, 4'b0100, 8'hC2, 1'b1, 2'd2};
    vecs[26] = '{1'b0, 8'h00, 4'h4, 4'hF, 1'b1, 4'b0100, 8'hC3, 1'b1, 2'd2};
    vecs[27] = '{1'b0, 8'h00, 4'h4, 4'hF, 1'b1, 4'b0000, 8'hC3, 1'b0, 2'd2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    chan_en   = 4'hF;
    out_ready = 4'hF;
`ifdef DEMUX_DISPATCH_CNT_EN
    cnt_clr   = 1'b0;
`endif
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      chan_en   = vecs[i].en;
      out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].ir));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vecs[i].od));
      chk($sformatf("v%0d_busy", i),      32'(busy),      32'(vecs[i].bsy));
      chk($sformatf("v%0d_out_sel", i),   32'(out_sel),   32'(vecs[i].sel));
      chk($sformatf("v%0d_onehot", i),    32'($countones(out_valid) <= 1), 32'd1);
    end

    // Reset asserted while holding: word discarded, next word goes to channel 0
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h88; chan_en = 4'hF; out_ready = 4'h0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("hold_pre_rst_valid", 32'(out_valid), 32'b1000);
    chk("hold_pre_rst_data", 32'(out_data), 32'h88);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_data", 32'(out_data), 32'h0);
    chk("async_rst_sel", 32'(out_sel), 32'h0);
`ifdef DEMUX_DISPATCH_CNT_EN
    chk("async_rst_cnt", cnt_flat, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 4'hF;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'b0001);
    chk("post_rst_data", 32'(out_data), 32'h99);

`ifdef DEMUX_DISPATCH_CNT_EN
    // Saturation after 300 words to channel 2; clear beats a coincident drain
    @(negedge clk);
    #1;
    chk("cnt_ch0_one", cnt_flat, 32'h0000_0001);
    chan_en = 4'h4;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(n);
    end
    @(negedge clk);
    in_valid = 1'b0; cnt_clr = 1'b1;
    #1;
    chk("cnt_ch2_sat", 32'(cnt_flat[23:16]), 32'd255);
    chk("cnt_drain_pending", 32'(out_valid), 32'b0100);
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    chk("cnt_clr_override", cnt_flat, 32'h0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("cnt_ch2_one", cnt_flat, 32'h0001_0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
